// File: rtl/vrf_read_arbiter.sv
// Round-robin arbiter sharing the single synchronous VRF read port among NUM_REQ readers.
// Grants are registered one-cycle pulses; read data returns two cycles later on a shared bus.
module vrf_read_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 1024,
  parameter int ADDR_WIDTH = 10,
  parameter int HOLDOFF    = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            read_req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] vrf_src_addr,
  output logic [NUM_REQ-1:0]            read_gnt,
  output logic [DATA_WIDTH-1:0]         data_send,
  output logic [NUM_REQ-1:0]            data_valid,
  input  logic                          vrf_wr_busy,
  output logic                          vrf_rd_en,
  output logic [ADDR_WIDTH-1:0]         vrf_rd_addr,
  input  logic [DATA_WIDTH-1:0]         vrf_rd_data
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int HO_W  = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  logic [PTR_W-1:0]          rr_ptr;
  logic [HO_W-1:0]           holdoff_cnt [NUM_REQ];
  logic [NUM_REQ-1:0]        eligible;
  logic [2*NUM_REQ-1:0]      elig_dbl;
  logic [NUM_REQ-1:0]        elig_rot;
  logic                      win_found;
  logic [PTR_W-1:0]          win_off;
  logic [PTR_W:0]            win_sum;
  logic [PTR_W-1:0]          win_idx;
  logic [PTR_W-1:0]          ptr_next;
  logic [NUM_REQ-1:0]        win_onehot;
  logic [ADDR_WIDTH-1:0]     win_addr;
  logic [PTR_W-1:0]          rd_id;
  logic                      rd_v2;
  logic [PTR_W-1:0]          rd_id2;
  logic [NUM_REQ-1:0]        ret_onehot;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = read_req[i] && (holdoff_cnt[i] == '0);
    end
  end

  // Rotate so the pointer lands on bit 0; the lowest set bit is then the round-robin winner.
  assign elig_dbl = {eligible, eligible} >> rr_ptr;
  assign elig_rot = elig_dbl[NUM_REQ-1:0];

  always_comb begin
    win_found = 1'b0;
    win_off   = '0;
    if (!vrf_wr_busy) begin
      for (int j = NUM_REQ - 1; j >= 0; j--) begin
        if (elig_rot[j]) begin
          win_found = 1'b1;
          win_off   = PTR_W'(j);
        end
      end
    end
  end

  always_comb begin
    win_sum = {1'b0, rr_ptr} + {1'b0, win_off};
    if (win_sum >= (PTR_W+1)'(NUM_REQ)) begin
      win_sum = win_sum - (PTR_W+1)'(NUM_REQ);
    end
    win_idx  = win_sum[PTR_W-1:0];
    ptr_next = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
  end

  always_comb begin
    win_onehot = '0;
    ret_onehot = '0;
    win_addr   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == PTR_W'(i)) begin
        win_onehot[i] = 1'b1;
        win_addr      = vrf_src_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
      if (rd_id2 == PTR_W'(i)) begin
        ret_onehot[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr      <= '0;
      read_gnt    <= '0;
      vrf_rd_en   <= 1'b0;
      vrf_rd_addr <= '0;
      rd_id       <= '0;
      rd_v2       <= 1'b0;
      rd_id2      <= '0;
      data_valid  <= '0;
      data_send   <= '0;
    end else begin
      read_gnt  <= win_found ? win_onehot : '0;
      vrf_rd_en <= win_found;
      if (win_found) begin
        vrf_rd_addr <= win_addr;
        rd_id       <= win_idx;
        rr_ptr      <= ptr_next;
      end
      // vrf_rd_en/rd_id form the first valid/ID stage; rd_v2/rd_id2 line up with vrf_rd_data.
      rd_v2      <= vrf_rd_en;
      rd_id2     <= rd_id;
      data_valid <= rd_v2 ? ret_onehot : '0;
      if (rd_v2) begin
        data_send <= vrf_rd_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        holdoff_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (win_found && (win_idx == PTR_W'(i))) begin
          holdoff_cnt[i] <= HO_W'(HOLDOFF);
        end else if (holdoff_cnt[i] != '0) begin
          holdoff_cnt[i] <= holdoff_cnt[i] - HO_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_vrf_read_arbiter.sv
// Bench for vrf_read_arbiter: cycle model predicts grants, a queue holds expected read returns.
module tb_vrf_read_arbiter;
  localparam int NR = 4;
  localparam int DW = 64;
  localparam int AW = 10;
  localparam int HO = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NR-1:0]    read_req = '0;
  logic [NR*AW-1:0] vrf_src_addr = '0;
  logic [NR-1:0]    read_gnt;
  logic [DW-1:0]    data_send;
  logic [NR-1:0]    data_valid;
  logic             vrf_wr_busy = 1'b0;
  logic             vrf_rd_en;
  logic [AW-1:0]    vrf_rd_addr;
  logic [DW-1:0]    vrf_rd_data = '0;

  vrf_read_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .HOLDOFF(HO)) dut (
    .clk(clk), .rst_n(rst_n), .read_req(read_req), .vrf_src_addr(vrf_src_addr),
    .read_gnt(read_gnt), .data_send(data_send), .data_valid(data_valid),
    .vrf_wr_busy(vrf_wr_busy), .vrf_rd_en(vrf_rd_en), .vrf_rd_addr(vrf_rd_addr),
    .vrf_rd_data(vrf_rd_data)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {22'h2A5A5A, a, 22'h15C3C3, ~a};
  endfunction

  // Synchronous VRF: data one cycle after the enable, junk otherwise.
  always @(posedge clk) begin
    if (vrf_rd_en) vrf_rd_data <= mem_word(vrf_rd_addr);
    else           vrf_rd_data <= 64'hDEAD_BEEF_0BAD_F00D;
  end

  typedef struct { int id; logic [DW-1:0] data; int due; } rd_t;
  typedef struct { int id; int cyc; } g_t;

  rd_t           sb[$];
  g_t            glog[$];
  int            n_chk = 0;
  int            n_err = 0;
  int            cyc = 0;
  int            m_ptr = 0;
  int            m_ho[NR];
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_send = '0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    vrf_src_addr[i*AW +: AW] = a;
  endtask

  task automatic model_reset();
    m_ptr = 0;
    m_addr = '0;
    m_send = '0;
    for (int i = 0; i < NR; i++) m_ho[i] = 0;
    sb.delete();
  endtask

  // Predict from the inputs sampled at the next edge, advance one cycle, check at negedge.
  task automatic step();
    int win;
    logic [NR-1:0] exp_gnt;
    logic exp_en;
    win = -1;
    if (!vrf_wr_busy) begin
      for (int j = 0; j < NR; j++) begin
        int idx;
        idx = (m_ptr + j) % NR;
        if (win < 0 && read_req[idx] && m_ho[idx] == 0) win = idx;
      end
    end
    for (int i = 0; i < NR; i++) if (m_ho[i] > 0) m_ho[i]--;
    exp_gnt = '0;
    exp_en = 1'b0;
    if (win >= 0) begin
      m_ho[win] = HO;
      m_ptr = (win + 1) % NR;
      m_addr = vrf_src_addr[win*AW +: AW];
      exp_gnt[win] = 1'b1;
      exp_en = 1'b1;
      sb.push_back('{win, mem_word(m_addr), cyc + 3});
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_eq("read_gnt", read_gnt, exp_gnt);
    check_eq("vrf_rd_en", vrf_rd_en, exp_en);
    check_eq("vrf_rd_addr", vrf_rd_addr, m_addr);
    for (int i = 0; i < NR; i++) if (read_gnt[i]) glog.push_back('{i, cyc});
    if (sb.size() > 0 && sb[0].due == cyc) begin
      rd_t r;
      logic [NR-1:0] ev;
      r = sb.pop_front();
      ev = '0;
      ev[r.id] = 1'b1;
      m_send = r.data;
      check_eq("data_valid", data_valid, ev);
      check_eq("data_send", data_send, r.data);
    end else begin
      check_eq("data_valid_idle", data_valid, '0);
      check_eq("data_send_hold", data_send, m_send);
    end
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    model_reset();
    #12;
    check_eq("rst_gnt", read_gnt, '0);
    check_eq("rst_rd_en", vrf_rd_en, '0);
    check_eq("rst_rd_addr", vrf_rd_addr, '0);
    check_eq("rst_data_valid", data_valid, '0);
    check_eq("rst_data_send", data_send, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // All four requesting continuously
    for (int i = 0; i < NR; i++) set_addr(i, AW'(10'h100 + i * 10'h011));
    glog.delete();
    read_req = 4'b1111;
    steps(8);
    read_req = '0;
    steps(4);
    check_eq("cont_count", glog.size(), 8);
    for (int k = 0; k < 8; k++) check_eq("cont_order", glog[k].id, k % NR);

    // Single request from requester 0 at address 5
    set_addr(0, 10'h005);
    glog.delete();
    read_req = 4'b0001;
    step();
    step();
    read_req = '0;
    step();
    check_eq("single_valid", data_valid, 4'b0001);
    check_eq("single_data", data_send, mem_word(10'h005));
    steps(3);
    check_eq("single_no_dup", glog.size(), 1);

    // Pointer fairness: grant 1 moves pointer to 2, then 1011 -> 3,0,1
    glog.delete();
    read_req = 4'b0010;
    step();
    read_req = 4'b1011;
    steps(3);
    read_req = '0;
    steps(4);
    check_eq("fair_count", glog.size(), 4);
    check_eq("fair_g1", glog[1].id, 3);
    check_eq("fair_g2", glog[2].id, 0);
    check_eq("fair_g3", glog[3].id, 1);

    // Write busy window
    glog.delete();
    read_req = 4'b0010;
    vrf_wr_busy = 1'b1;
    steps(3);
    check_eq("busy_no_gnt", glog.size(), 0);
    vrf_wr_busy = 1'b0;
    step();
    read_req = '0;
    check_eq("busy_after_gnt", read_gnt, 4'b0010);
    steps(4);

    // Re-request after holdoff
    glog.delete();
    read_req = 4'b0010;
    step();
    steps(2);
    read_req = '0;
    step();
    read_req = 4'b0010;
    step();
    read_req = '0;
    steps(4);
    check_eq("rereq_count", glog.size(), 2);
    check_eq("rereq_gap", glog[1].cyc - glog[0].cyc, 4);

    // Async reset in T+1 after a grant to requester 2
    glog.delete();
    read_req = 4'b0100;
    step();
    read_req = '0;
    step();
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_gnt", read_gnt, '0);
    check_eq("mid_rst_rd_en", vrf_rd_en, '0);
    check_eq("mid_rst_rd_addr", vrf_rd_addr, '0);
    check_eq("mid_rst_valid", data_valid, '0);
    check_eq("mid_rst_data", data_send, '0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    steps(3);
    glog.delete();
    read_req = 4'b1010;
    step();
    read_req = '0;
    check_eq("post_rst_gnt", read_gnt, 4'b0010);
    steps(4);

    // Random traffic against the cycle model
    for (int k = 0; k < 60; k++) begin
      read_req = NR'($urandom);
      vrf_wr_busy = ($urandom_range(0, 4) == 0);
      for (int i = 0; i < NR; i++) set_addr(i, AW'($urandom));
      step();
    end
    read_req = '0;
    vrf_wr_busy = 1'b0;
    steps(4);
    check_eq("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
